// File: rtl/pito_uart_tx_ctrl.sv
// Queues core UART stores in a FIFO and feeds pito_uart one byte at a time over wr/busy.
// Define PITO_UART_TX_DROP_CNT_EN to build the saturating drop counter; otherwise drop_cnt is 0.
module pito_uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int BUSY_WAIT  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_req,
    input  logic [7:0]                    wr_data,
    input  logic                          flush,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx_busy,
    output logic [7:0]                    drop_cnt,
    output logic                          uart_wr,
    output logic [7:0]                    uart_tx_data,
    input  logic                          uart_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      tx_data_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic            push;
    logic            pop;

    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign level   = level_q;
    assign tx_busy = (level_q != '0) || (state_q != S_IDLE);
    assign uart_wr = (state_q == S_LAUNCH);
    assign uart_tx_data = tx_data_q;

    // A pop frees the head slot on the same edge, so a push at full is still taken then.
    assign pop  = (state_q == S_IDLE) && (level_q != '0);
    assign push = wr_req && !flush && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            level_d  = level_q + LW'(push) - LW'(pop);
        end
    end

    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT_BUSY;
                guard_d = '0;
            end
            S_WAIT_BUSY: begin
                // A UART that never raises busy must not hang the queue.
                if (uart_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (guard_q == GW'(BUSY_WAIT - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!uart_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            guard_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tx_data_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            guard_q  <= guard_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (pop) tx_data_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

`ifdef PITO_UART_TX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;
    logic       drop;

    assign drop     = wr_req && !flush && full && !pop;
    assign drop_cnt = drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pito_uart_tx_ctrl.sv
// Randomized bench for pito_uart_tx_ctrl against a queue-based scheduler model and a simple UART model.
module tb_pito_uart_tx_ctrl;
    localparam int DEPTH = 16;
    localparam int BW    = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wr_req;
    logic [7:0]               wr_data;
    logic                     flush;
    logic                     full;
    logic [$clog2(DEPTH):0]   level;
    logic                     tx_busy;
    logic [7:0]               drop_cnt;
    logic                     uart_wr;
    logic [7:0]               uart_tx_data;
    logic                     uart_busy;

    pito_uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .BUSY_WAIT(BW)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .flush(flush),
        .full(full), .level(level), .tx_busy(tx_busy), .drop_cnt(drop_cnt),
        .uart_wr(uart_wr), .uart_tx_data(uart_tx_data), .uart_busy(uart_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // UART model: busy rises u_delay cycles after a launch and lasts u_len cycles.
    int   u_delay = 0;
    int   u_len   = 3;
    bit   u_never = 1'b0;
    bit   u_stuck = 1'b0;
    int   u_dcnt;
    int   u_lcnt;
    logic u_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_busy <= 1'b0;
            u_pend    <= 1'b0;
            u_dcnt    <= 0;
            u_lcnt    <= 0;
        end else if (uart_wr && !u_never) begin
            u_lcnt <= u_len;
            if (u_delay == 0) uart_busy <= 1'b1;
            else begin
                u_pend <= 1'b1;
                u_dcnt <= u_delay - 1;
            end
        end else if (u_pend) begin
            if (u_dcnt == 0) begin
                uart_busy <= 1'b1;
                u_pend    <= 1'b0;
            end else u_dcnt <= u_dcnt - 1;
        end else if (uart_busy && !u_stuck) begin
            if (u_lcnt <= 1) uart_busy <= 1'b0;
            else u_lcnt <= u_lcnt - 1;
        end
    end

    // Reference model: byte queue plus a sender that is either free or carrying one byte.
    logic [7:0] mq[$];
    bit         m_send, m_launch, m_seen;
    int         m_wait, m_drop;
    logic [7:0] m_data;
    int         cyc = 0;
    logic [7:0] rx_log[$];
    int         rx_cyc[$];

    task automatic model_step();
        bit pop, acc, drp;
        if (rst) begin
            mq.delete();
            m_send = 0; m_launch = 0; m_seen = 0; m_wait = 0; m_drop = 0; m_data = 8'd0;
        end else begin
            cyc++;
            if (uart_wr) begin
                rx_log.push_back(uart_tx_data);
                rx_cyc.push_back(cyc);
            end
            pop = !m_send && (mq.size() != 0);
            acc = wr_req && !flush && ((mq.size() < DEPTH) || pop);
            drp = wr_req && !flush && (mq.size() == DEPTH) && !pop;
            if (m_send) begin
                if (m_launch) begin
                    m_launch = 0; m_wait = 0; m_seen = 0;
                end else if (!m_seen) begin
                    if (uart_busy) m_seen = 1;
                    else if (m_wait == BW - 1) m_send = 0;
                    else m_wait++;
                end else if (!uart_busy) m_send = 0;
            end
            if (pop) begin
                m_data = mq.pop_front();
                m_send = 1;
                m_launch = 1;
            end
            if (flush) mq.delete();
            else if (acc) mq.push_back(wr_data);
            if (drp && m_drop < 255) m_drop++;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    function automatic int exp_drop();
`ifdef PITO_UART_TX_DROP_CNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        chk("level", level, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("tx_busy", tx_busy, (mq.size() != 0) || m_send);
        chk("uart_wr", uart_wr, m_launch);
        chk("tx_data", uart_tx_data, m_data);
        chk("drop_cnt", drop_cnt, exp_drop());
        chk("wr_while_busy", uart_wr & uart_busy, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_req = 1'b1; wr_data = b;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((tx_busy || uart_busy) && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_random(input int cycles, input int p_wr, input int p_fl);
        for (int i = 0; i < cycles; i++) begin
            wr_req  = ($urandom_range(99) < p_wr);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(99) < p_fl);
            tick();
        end
        wr_req = 1'b0;
        flush  = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] b;

    initial begin
        rst = 1'b1; wr_req = 1'b0; wr_data = 8'd0; flush = 1'b0;
        tick();
        tick();
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_uart_wr", uart_wr, 0);
        chk("rst_tx_data", uart_tx_data, 0);
        rst = 1'b0;
        tick();

        // Single byte: launch in the second cycle after the accepting edge.
        wr_req = 1'b1; wr_data = 8'h41;
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(negedge clk);
        chk("sb_wr_c1", uart_wr, 0);
        chk("sb_busy_c1", tx_busy, 1);
        @(negedge clk);
        chk("sb_wr_c2", uart_wr, 1);
        chk("sb_data_c2", uart_tx_data, 8'h41);
        @(posedge clk); #1;
        wait_idle(200);

        // Randomized traffic under several UART behaviours.
        for (int ph = 0; ph < 4; ph++) begin
            u_delay = $urandom_range(1);
            u_len   = $urandom_range(10, 1);
            u_never = (ph == 3);
            run_random(200, 20 + 20 * ph, 3);
            wait_idle(1000);
        end
        u_never = 1'b0;

        // Burst of 16 with a 10-cycle busy per byte.
        u_delay = 0; u_len = 10;
        rx_log.delete();
        wr_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            tick();
        end
        wr_req = 1'b0;
        wait_idle(1000);
        chk("burst_count", rx_log.size(), 16);
        for (int i = 0; i < 16 && i < rx_log.size(); i++) chk("burst_byte", rx_log[i], i);
        chk("burst_level", level, 0);

        // UART never raises busy: guard timeout spaces launches by BUSY_WAIT+2.
        u_never = 1'b1;
        rx_log.delete(); rx_cyc.delete();
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_req = 1'b0;
        wait_idle(200);
        chk("nb_count", rx_log.size(), 3);
        if (rx_cyc.size() == 3) begin
            chk("nb_gap0", rx_cyc[1] - rx_cyc[0], BW + 2);
            chk("nb_gap1", rx_cyc[2] - rx_cyc[1], BW + 2);
            chk("nb_byte2", rx_log[2], 8'hC2);
        end
        u_never = 1'b0;

        // Overflow with the UART stuck busy, then push-at-full against pops.
        do_reset();
        u_stuck = 1'b1; u_delay = 0; u_len = 2;
        rx_log.delete(); exp_q.delete();
        push(8'hA5);
        exp_q.push_back(8'hA5);
        repeat (4) tick();
        wr_req = 1'b1;
        for (int i = 0; i < 19; i++) begin
            b = 8'($urandom);
            wr_data = b;
            if (i < 16) exp_q.push_back(b);
            tick();
        end
        wr_req = 1'b0;
        chk("ovf_level", level, 16);
        chk("ovf_full", full, 1);
`ifdef PITO_UART_TX_DROP_CNT_EN
        chk("ovf_drop", drop_cnt, 3);
`else
        chk("ovf_drop", drop_cnt, 0);
`endif
        u_stuck = 1'b0;
        wr_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'($urandom);
            tick();
        end
        wr_req = 1'b0;
        chk("fullpop_level", level, 16);
        wait_idle(2000);
        chk("ovf_rx_min", rx_log.size() >= 17, 1);
        for (int i = 0; i < 17 && i < rx_log.size(); i++) chk("ovf_order", rx_log[i], exp_q[i]);

        // Flush with five queued and one in flight, plus a coincident push.
        do_reset();
        u_len = 8;
        rx_log.delete();
        wr_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h10 + i);
            tick();
        end
        chk("fl_level_pre", level, 5);
        wr_data = 8'hEE; flush = 1'b1;
        tick();
        wr_req = 1'b0; flush = 1'b0;
        chk("fl_level", level, 0);
        wait_idle(200);
        chk("fl_rx_count", rx_log.size(), 1);
        if (rx_log.size() > 0) chk("fl_rx_byte", rx_log[0], 8'h10);
        chk("fl_drop", drop_cnt, 0);

        // Async reset while waiting for busy to drop.
        u_stuck = 1'b1;
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h5A + i);
            tick();
        end
        wr_req = 1'b0;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_level", level, 0);
        chk("ar_full", full, 0);
        chk("ar_tx_busy", tx_busy, 0);
        chk("ar_uart_wr", uart_wr, 0);
        chk("ar_tx_data", uart_tx_data, 0);
        chk("ar_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        u_stuck = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
